// File: rtl/cache_pkg.sv
// Shared types and defaults for the direct-mapped write-back cache controller.
package cache_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_FILL,
    S_DONE
  } state_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/cache_ctrl_if.sv
// CPU-side and memory-side bus of the cache controller; slave = controller view.
interface cache_ctrl_if #(
  parameter int ADDR_W = cache_pkg::ADDR_W_DEF,
  parameter int DATA_W = cache_pkg::DATA_W_DEF
);
  logic              cpu_req;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_hit;
  logic              cpu_err;
  logic              mem_req;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_err;

  modport slave (
    input  cpu_req, cpu_write, cpu_addr, cpu_wdata, mem_ack, mem_rdata, mem_err,
    output cpu_ready, cpu_done, cpu_rdata, cpu_hit, cpu_err,
           mem_req, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_write, cpu_addr, cpu_wdata, mem_ack, mem_rdata, mem_err,
    input  cpu_ready, cpu_done, cpu_rdata, cpu_hit, cpu_err,
           mem_req, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_line_store.sv
// Per-line valid/dirty/tag/data storage: one combinational read index, one write port.
module cache_line_store #(
  parameter int LINES  = 4,
  parameter int IDX_W  = 2,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_valid,
  input  logic              wr_dirty,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);
  logic [LINES-1:0]             valid_q, dirty_q;
  logic [LINES-1:0][TAG_W-1:0]  tag_q;
  logic [LINES-1:0][DATA_W-1:0] data_q;

  // Only the state bits need reset; tag/data are qualified by valid.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_valid;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];
endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller with hit/miss statistics.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LINES  = 4
) (
  input  logic        clock,
  input  logic        resetn,
  cache_ctrl_if.slave bus,
  output logic [7:0]  hit_count,
  output logic [7:0]  miss_count
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              hit_q, hit_d;
  logic              err_q, err_d;
  logic [7:0]        hit_cnt_q, hit_cnt_d;
  logic [7:0]        miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              ln_valid, ln_dirty;
  logic [TAG_W-1:0]  ln_tag;
  logic [DATA_W-1:0] ln_data;
  logic              wr_en, wr_valid, wr_dirty;
  logic [TAG_W-1:0]  wr_tag;
  logic [DATA_W-1:0] wr_data;
  logic              lookup_hit;

  assign idx        = addr_q[IDX_W-1:0];
  assign tag        = addr_q[ADDR_W-1:IDX_W];
  assign lookup_hit = ln_valid && (ln_tag == tag);

  cache_line_store #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_store (
    .clock   (clock),
    .resetn  (resetn),
    .rd_idx  (idx),
    .rd_valid(ln_valid),
    .rd_dirty(ln_dirty),
    .rd_tag  (ln_tag),
    .rd_data (ln_data),
    .wr_en   (wr_en),
    .wr_idx  (idx),
    .wr_valid(wr_valid),
    .wr_dirty(wr_dirty),
    .wr_tag  (wr_tag),
    .wr_data (wr_data)
  );

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    hit_d      = hit_q;
    err_d      = err_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wr_en      = 1'b0;
    wr_valid   = ln_valid;
    wr_dirty   = ln_dirty;
    wr_tag     = ln_tag;
    wr_data    = ln_data;
    case (state_q)
      S_IDLE: if (bus.cpu_req) begin
        write_d = bus.cpu_write;
        addr_d  = bus.cpu_addr;
        wdata_d = bus.cpu_wdata;
        rdata_d = '0;
        hit_d   = 1'b0;
        err_d   = 1'b0;
        state_d = S_LOOKUP;
      end
      S_LOOKUP: if (lookup_hit) begin
        hit_d     = 1'b1;
        hit_cnt_d = sat_inc(hit_cnt_q);
        state_d   = S_DONE;
        if (write_q) begin
          wr_en    = 1'b1;
          wr_dirty = 1'b1;
          wr_data  = wdata_q;
        end else begin
          rdata_d = ln_data;
        end
      end else begin
        miss_cnt_d = sat_inc(miss_cnt_q);
        state_d    = (ln_valid && ln_dirty) ? S_WRITEBACK : S_FILL;
      end
      S_WRITEBACK: if (bus.mem_ack) begin
        if (bus.mem_err) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wr_en    = 1'b1;
          wr_dirty = 1'b0;
          state_d  = S_FILL;
        end
      end
      S_FILL: if (bus.mem_ack) begin
        state_d = S_DONE;
        if (bus.mem_err) begin
          err_d = 1'b1;
        end else begin
          // Allocate then merge: a write miss lands the CPU data over the fill.
          wr_en    = 1'b1;
          wr_valid = 1'b1;
          wr_tag   = tag;
          wr_dirty = write_q;
          wr_data  = write_q ? wdata_q : bus.mem_rdata;
          rdata_d  = write_q ? '0 : bus.mem_rdata;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      hit_q      <= 1'b0;
      err_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      hit_q      <= hit_d;
      err_q      <= err_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // All bus outputs are Moore decodes of state so reset clears them asynchronously.
  assign bus.cpu_ready = (state_q == S_IDLE);
  assign bus.cpu_done  = (state_q == S_DONE);
  assign bus.cpu_rdata = (state_q == S_DONE) ? rdata_q : '0;
  assign bus.cpu_hit   = (state_q == S_DONE) && hit_q;
  assign bus.cpu_err   = (state_q == S_DONE) && err_q;
  assign bus.mem_req   = (state_q == S_WRITEBACK) || (state_q == S_FILL);
  assign bus.mem_write = (state_q == S_WRITEBACK);
  assign bus.mem_addr  = (state_q == S_WRITEBACK) ? {ln_tag, idx} :
                         (state_q == S_FILL)      ? addr_q : '0;
  assign bus.mem_wdata = (state_q == S_WRITEBACK) ? ln_data : '0;
  assign hit_count     = hit_cnt_q;
  assign miss_count    = miss_cnt_q;
endmodule

// File: tb/tb_cache_ctrl.sv
// Random + directed bench for cache_ctrl against an array-based cache/memory model.
module tb_cache_ctrl;
  localparam int AW = 8, DW = 8, LINES = 4;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic [7:0] hit_count, miss_count;

  cache_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  cache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LINES(LINES)) dut (
    .clock(clock), .resetn(resetn), .bus(bus),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {bit wr; logic [7:0] addr; logic [7:0] data;} tx_t;

  // Environment memory (answers the DUT) and observed transactions
  logic [7:0] env_mem [256];
  bit         env_present [256];
  tx_t        obs_q[$];

  // Reference model: cache contents, shadow memory, counters, expectations
  bit         r_valid [LINES];
  bit         r_dirty [LINES];
  int         r_tag [LINES];
  logic [7:0] r_data [LINES];
  logic [7:0] r_mem [256];
  bit         r_present [256];
  int         r_hits, r_misses;
  tx_t        exp_q[$];
  bit         e_hit, e_err;
  logic [7:0] e_rdata;

  logic [7:0] o_rdata;
  bit         o_hit, o_err;
  int         o_lat;

  function automatic void ref_reset();
    for (int i = 0; i < LINES; i++) begin r_valid[i] = 0; r_dirty[i] = 0; end
    r_hits = 0;
    r_misses = 0;
  endfunction

  function automatic void ref_access(input bit wr, input logic [7:0] a, input logic [7:0] wd);
    int idx, tg, victim;
    idx = int'(a) % LINES;
    tg  = int'(a) / LINES;
    exp_q.delete();
    e_hit = 0; e_err = 0; e_rdata = 8'h00;
    if (r_valid[idx] && r_tag[idx] == tg) begin
      e_hit = 1;
      if (r_hits < 255) r_hits++;
      if (wr) begin r_data[idx] = wd; r_dirty[idx] = 1; end
      else e_rdata = r_data[idx];
      return;
    end
    if (r_misses < 255) r_misses++;
    if (r_valid[idx] && r_dirty[idx]) begin
      victim = r_tag[idx] * LINES + idx;
      exp_q.push_back('{1'b1, 8'(victim), r_data[idx]});
      if (!r_present[victim]) begin e_err = 1; return; end
      r_mem[victim] = r_data[idx];
      r_dirty[idx] = 0;
    end
    exp_q.push_back('{1'b0, a, 8'h00});
    if (!r_present[a]) begin e_err = 1; return; end
    r_valid[idx] = 1;
    r_tag[idx]   = tg;
    r_data[idx]  = wr ? wd : r_mem[a];
    r_dirty[idx] = wr;
    e_rdata      = wr ? 8'h00 : r_mem[a];
  endfunction

  // Memory responder: ack two cycles after the request, plus stray acks while idle
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ack = 0; bus.mem_rdata = 0; bus.mem_err = 0;
    forever begin
      @(negedge clock);
      bus.mem_ack = 0; bus.mem_rdata = 0; bus.mem_err = 0;
      if (!resetn) cnt = 0;
      else if (bus.mem_req) begin
        cnt++;
        if (cnt >= 2) begin
          cnt = 0;
          bus.mem_ack = 1;
          bus.mem_err = !env_present[bus.mem_addr];
          obs_q.push_back('{bus.mem_write, bus.mem_addr, bus.mem_wdata});
          if (bus.mem_write) begin
            if (env_present[bus.mem_addr]) env_mem[bus.mem_addr] = bus.mem_wdata;
          end else begin
            bus.mem_rdata = env_present[bus.mem_addr] ? env_mem[bus.mem_addr] : 8'($urandom);
          end
        end
      end else begin
        cnt = 0;
        if ($urandom_range(0, 3) == 0) begin
          bus.mem_ack = 1;
          bus.mem_err = 1'($urandom_range(0, 1));
          bus.mem_rdata = 8'($urandom);
        end
      end
    end
  end

  task automatic do_op(input bit wr, input logic [7:0] a, input logic [7:0] wd, input string nm);
    bit done;
    ref_access(wr, a, wd);
    obs_q.delete();
    @(negedge clock);
    chk({nm, " ready"}, bus.cpu_ready, 1);
    bus.cpu_req = 1; bus.cpu_write = wr; bus.cpu_addr = a; bus.cpu_wdata = wd;
    @(negedge clock);
    o_lat = 1;
    done = 0;
    while (o_lat <= 40 && !done) begin
      if (bus.cpu_done) done = 1;
      else begin
        // Requests while busy must be ignored
        bus.cpu_req = 1'($urandom_range(0, 1));
        bus.cpu_write = 1'($urandom_range(0, 1));
        bus.cpu_addr = 8'($urandom);
        bus.cpu_wdata = 8'($urandom);
        @(negedge clock);
        o_lat++;
      end
    end
    bus.cpu_req = 0;
    chk({nm, " done"}, done, 1);
    o_rdata = bus.cpu_rdata; o_hit = bus.cpu_hit; o_err = bus.cpu_err;
    chk({nm, " hit"}, o_hit, e_hit);
    chk({nm, " err"}, o_err, e_err);
    if (!wr) chk({nm, " rdata"}, o_rdata, e_rdata);
    if (e_hit) chk({nm, " latency"}, o_lat, 2);
    chk({nm, " hit_count"}, hit_count, r_hits);
    chk({nm, " miss_count"}, miss_count, r_misses);
    chk({nm, " mem_req in done"}, {bus.mem_req, bus.mem_addr}, 0);
    chk({nm, " n_tx"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({nm, " tx_wr"}, obs_q[i].wr, exp_q[i].wr);
      chk({nm, " tx_addr"}, obs_q[i].addr, exp_q[i].addr);
      if (exp_q[i].wr) chk({nm, " tx_wdata"}, obs_q[i].data, exp_q[i].data);
    end
    @(negedge clock);
    chk({nm, " done pulse"}, {bus.cpu_done, bus.cpu_hit, bus.cpu_err, bus.cpu_rdata}, 0);
  endtask

  task automatic apply_reset(input string nm);
    bus.cpu_req = 0;
    resetn = 0;
    #1;
    chk({nm, " rst ready"}, bus.cpu_ready, 1);
    chk({nm, " rst mem_req"}, {bus.mem_req, bus.mem_write, bus.mem_addr, bus.mem_wdata}, 0);
    chk({nm, " rst cpu outs"}, {bus.cpu_done, bus.cpu_hit, bus.cpu_err, bus.cpu_rdata}, 0);
    chk({nm, " rst counters"}, {hit_count, miss_count}, 0);
    repeat (2) begin
      @(negedge clock);
      chk({nm, " no done in rst"}, bus.cpu_done, 0);
    end
    resetn = 1;
    ref_reset();
  endtask

  initial begin
    logic [7:0] pool [8];
    bit seen;
    pool = '{8'h00, 8'h65, 8'h66, 8'h67, 8'h69, 8'h30, 8'h41, 8'h25};
    for (int i = 0; i < 256; i++) begin
      env_present[i] = 0; env_mem[i] = 0; r_present[i] = 0; r_mem[i] = 0;
    end
    env_present[8'h00] = 1; env_mem[8'h00] = 8'h05;
    env_present[8'h65] = 1; env_mem[8'h65] = 8'h03;
    env_present[8'h66] = 1; env_mem[8'h66] = 8'h01;
    env_present[8'h67] = 1; env_mem[8'h67] = 8'h00;
    env_present[8'h69] = 1; env_mem[8'h69] = 8'h07;
    for (int i = 0; i < 256; i++) begin r_present[i] = env_present[i]; r_mem[i] = env_mem[i]; end
    bus.cpu_req = 0; bus.cpu_write = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;

    @(negedge clock);
    apply_reset("init");

    do_op(0, 8'h65, 8'h00, "rd65 cold");
    chk("rd65 cold value", o_rdata, 8'h03);
    chk("rd65 cold is miss", {o_hit, miss_count}, {1'b0, 8'd1});
    chk("rd65 cold fill addr", (obs_q.size() == 1) ? obs_q[0].addr : 8'hXX, 8'h65);

    do_op(0, 8'h65, 8'h00, "rd65 warm");
    chk("rd65 warm", {o_hit, o_rdata, hit_count}, {1'b1, 8'h03, 8'd1});
    chk("rd65 warm no mem", obs_q.size(), 0);
    chk("rd65 warm latency", o_lat, 2);

    do_op(1, 8'h65, 8'hAA, "wr65");
    chk("wr65 hit no mem", {o_hit, 8'(obs_q.size())}, {1'b1, 8'd0});
    do_op(0, 8'h69, 8'h00, "rd69 evict");
    chk("rd69 evict n_tx", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("rd69 wb", {obs_q[0].wr, obs_q[0].addr, obs_q[0].data}, {1'b1, 8'h65, 8'hAA});
      chk("rd69 fill", {obs_q[1].wr, obs_q[1].addr}, {1'b0, 8'h69});
    end
    chk("rd69 value", o_rdata, 8'h07);

    do_op(0, 8'h30, 8'h00, "rd30 absent");
    chk("rd30 absent", {o_err, o_hit, o_rdata}, {1'b1, 1'b0, 8'h00});
    do_op(0, 8'h30, 8'h00, "rd30 again");
    chk("rd30 again misses", {o_err, o_hit}, {1'b1, 1'b0});

    // Dirty line that must be dropped by the reset below
    do_op(1, 8'h66, 8'h5A, "wr66 dirty");
    @(negedge clock);
    bus.cpu_req = 1; bus.cpu_write = 0; bus.cpu_addr = 8'h67;
    @(negedge clock);
    bus.cpu_req = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.mem_req && !bus.mem_write) seen = 1;
      else @(negedge clock);
    end
    chk("fill reached", seen, 1);
    apply_reset("mid fill");
    do_op(0, 8'h65, 8'h00, "rd65 post rst");
    chk("rd65 post rst miss", {o_hit, o_rdata}, {1'b0, 8'hAA});
    do_op(0, 8'h66, 8'h00, "rd66 post rst");
    chk("rd66 dirty dropped", o_rdata, 8'h01);

    for (int n = 0; n < 150; n++)
      do_op(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 8'($urandom), "rand");

    @(negedge clock);
    apply_reset("pre sat");
    do_op(0, 8'h65, 8'h00, "sat prime");
    for (int n = 0; n < 300; n++) do_op(0, 8'h65, 8'h00, "sat hit");
    chk("hit_count saturated", hit_count, 8'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
